// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared constants and types for the seven-segment capture block.
//   - SEG_GLYPH_0..SEG_GLYPH_9 : legal glyphs, bit order {a,b,c,d,e,f,g}, 1 = lit
//   - BCD_INVALID              : value reported for an unrecognised glyph
//   - cap_state_e              : frame output FSM states
package seven_seg_pkg;

   localparam logic [6:0] SEG_GLYPH_0 = 7'h7E;
   localparam logic [6:0] SEG_GLYPH_1 = 7'h30;
   localparam logic [6:0] SEG_GLYPH_2 = 7'h6D;
   localparam logic [6:0] SEG_GLYPH_3 = 7'h79;
   localparam logic [6:0] SEG_GLYPH_4 = 7'h33;
   localparam logic [6:0] SEG_GLYPH_5 = 7'h5B;
   localparam logic [6:0] SEG_GLYPH_6 = 7'h5F;
   localparam logic [6:0] SEG_GLYPH_7 = 7'h70;
   localparam logic [6:0] SEG_GLYPH_8 = 7'h7F;
   localparam logic [6:0] SEG_GLYPH_9 = 7'h7B;

   localparam logic [3:0] BCD_INVALID = 4'hF;

   typedef enum logic {
      EMPTY,
      FULL
   } cap_state_e;

endpackage

// File: rtl/seven_seg_glyph_decode.sv
// seven_seg_glyph_decode: combinational inverse of the BCD-to-seven-segment driver.
// Ports:
//   glyph [6:0] in  : segment pattern {a,b,c,d,e,f,g}, active-high
//   bcd   [3:0] out : decoded digit 0-9, BCD_INVALID for any other pattern
//   err         out : 1 when glyph is not one of the ten legal digit glyphs
module seven_seg_glyph_decode
   import seven_seg_pkg::*;
(
   input  logic [6:0] glyph,
   output logic [3:0] bcd,
   output logic       err
);

   always_comb begin
      bcd = BCD_INVALID;
      err = 1'b0;
      case (glyph)
         SEG_GLYPH_0: bcd = 4'd0;
         SEG_GLYPH_1: bcd = 4'd1;
         SEG_GLYPH_2: bcd = 4'd2;
         SEG_GLYPH_3: bcd = 4'd3;
         SEG_GLYPH_4: bcd = 4'd4;
         SEG_GLYPH_5: bcd = 4'd5;
         SEG_GLYPH_6: bcd = 4'd6;
         SEG_GLYPH_7: bcd = 4'd7;
         SEG_GLYPH_8: bcd = 4'd8;
         SEG_GLYPH_9: bcd = 4'd9;
         default:     err = 1'b1;
      endcase
   end

endmodule

// File: rtl/seven_seg_capture.sv
// seven_seg_capture: samples a time-multiplexed seven-segment bus, qualifies each digit
// for stability, decodes it back to BCD and presents full frames on a valid/ready port.
// Optional build macro SEG_ACTIVE_LOW_EN: seg_in and dig_sel are inverted at the input
// (common-anode display); all-ones dig_sel is then the blanking state.
// Ports:
//   clk                          in  : clock, rising edge
//   reset                        in  : asynchronous active-high reset
//   seg_in      [6:0]            in  : segments {a,b,c,d,e,f,g}
//   dig_sel     [NUM_DIGITS-1:0] in  : one-hot digit select
//   frame_ready                  in  : consumer accepts frame
//   frame_valid                  out : frame available
//   frame_bcd   [4*NUM_DIGITS-1:0] out : digit i in bits [4i+3:4i]
//   frame_err   [NUM_DIGITS-1:0] out : bit i = digit i was not a legal glyph
//   overrun                      out : one-cycle pulse, a completed frame was dropped
module seven_seg_capture
   import seven_seg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS    = 4,
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [6:0]              seg_in,
   input  logic [NUM_DIGITS-1:0]   dig_sel,
   input  logic                    frame_ready,
   output logic                    frame_valid,
   output logic [4*NUM_DIGITS-1:0] frame_bcd,
   output logic [NUM_DIGITS-1:0]   frame_err,
   output logic                    overrun
);

   localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
   localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned SW = 7 + NUM_DIGITS;
   localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_CYCLES);

   // Input boundary polarity
   logic [6:0]            seg_s;
   logic [NUM_DIGITS-1:0] sel_s;

`ifdef SEG_ACTIVE_LOW_EN
   assign seg_s = ~seg_in;
   assign sel_s = ~dig_sel;
`else
   assign seg_s = seg_in;
   assign sel_s = dig_sel;
`endif

   // Stability qualification
   logic [SW-1:0] sample_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          one_hot, same, capture;

   assign one_hot = $onehot(sel_s);
   assign same    = ({seg_s, sel_s} == sample_q);

   always_comb begin
      cnt_d   = '0;
      capture = 1'b0;
      if (one_hot) begin
         if (same) begin
            cnt_d = (cnt_q == STABLE_MAX) ? cnt_q : cnt_q + CW'(1);
         end else begin
            cnt_d = CW'(1);
         end
         // Capture only on arrival at the threshold, not while sitting saturated.
         // A fresh sample with STABLE_CYCLES=1 arrives at 1 even if cnt_q was already 1.
         capture = (cnt_d == STABLE_MAX) && !(same && (cnt_q == STABLE_MAX));
      end
   end

   // Slot index from the one-hot select
   logic [IW-1:0] idx;

   always_comb begin
      idx = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (sel_s[i]) idx = IW'(i);
      end
   end

   logic [3:0] dec_bcd;
   logic       dec_err;

   seven_seg_glyph_decode u_decode (
      .glyph (seg_s),
      .bcd   (dec_bcd),
      .err   (dec_err)
   );

   // Per-slot collection
   logic [4*NUM_DIGITS-1:0] slot_bcd_q, slot_bcd_d;
   logic [NUM_DIGITS-1:0]   slot_err_q, slot_err_d;
   logic [NUM_DIGITS-1:0]   cap_q, cap_d, cap_set;
   logic                    complete;

   always_comb begin
      slot_bcd_d = slot_bcd_q;
      slot_err_d = slot_err_q;
      cap_set    = cap_q;
      if (capture) begin
         slot_bcd_d[4*idx +: 4] = dec_bcd;
         slot_err_d[idx]        = dec_err;
         cap_set                = cap_q | sel_s;
      end
      complete = &cap_set;
      // Clear on completion so the next frame starts collecting immediately
      cap_d    = complete ? '0 : cap_set;
   end

   // Frame output FSM
   cap_state_e              state_q, state_d;
   logic [4*NUM_DIGITS-1:0] out_bcd_q, out_bcd_d;
   logic [NUM_DIGITS-1:0]   out_err_q, out_err_d;
   logic                    overrun_q, overrun_d;
   logic                    load;

   always_comb begin
      state_d   = state_q;
      load      = 1'b0;
      overrun_d = 1'b0;
      case (state_q)
         EMPTY: begin
            if (complete) begin
               load    = 1'b1;
               state_d = FULL;
            end
         end
         FULL: begin
            if (frame_ready) begin
               if (complete) begin
                  load = 1'b1;
               end else begin
                  state_d = EMPTY;
               end
            end else if (complete) begin
               overrun_d = 1'b1;
            end
         end
         default: state_d = EMPTY;
      endcase
      out_bcd_d = load ? slot_bcd_d : out_bcd_q;
      out_err_d = load ? slot_err_d : out_err_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sample_q   <= '0;
         cnt_q      <= '0;
         slot_bcd_q <= '0;
         slot_err_q <= '0;
         cap_q      <= '0;
         state_q    <= EMPTY;
         out_bcd_q  <= '0;
         out_err_q  <= '0;
         overrun_q  <= 1'b0;
      end else begin
         sample_q   <= {seg_s, sel_s};
         cnt_q      <= cnt_d;
         slot_bcd_q <= slot_bcd_d;
         slot_err_q <= slot_err_d;
         cap_q      <= cap_d;
         state_q    <= state_d;
         out_bcd_q  <= out_bcd_d;
         out_err_q  <= out_err_d;
         overrun_q  <= overrun_d;
      end
   end

   assign frame_valid = (state_q == FULL);
   assign frame_bcd   = out_bcd_q;
   assign frame_err   = out_err_q;
   assign overrun     = overrun_q;

endmodule
